// File: rtl/max_pool_stream.sv
// max_pool_stream: streaming 2x2/stride-2 max or floor-average pooling over a raster pixel stream
module max_pool_stream #(
  parameter int DATA_W = 16,
  parameter int CH     = 6,
  parameter int FM_W   = 28,
  parameter int FM_H   = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_last
);
  localparam int CW = $clog2(FM_W);
  localparam int RW = $clog2(FM_H);
  localparam int LW = DATA_W + 1;
  localparam int LD = FM_W / 2;
  localparam int AW = (LD > 1) ? $clog2(LD) : 1;

  typedef enum logic [1:0] {IDLE, EVEN, ODD} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic                mode_r, avg, odd_row, fire, end_row, end_frame, load;
  logic [CH*DATA_W-1:0] hold, result;
  logic [CH*LW-1:0]    pair, lb_rd;
  logic [CH*LW-1:0]    lb [LD];
  logic [AW-1:0]       lb_addr;

  assign in_ready  = rst && (!out_valid || out_ready);
  assign fire      = in_valid && in_ready;
  assign end_row   = col == CW'(FM_W - 1);
  assign end_frame = end_row && row == RW'(FM_H - 1);
  assign load      = fire && odd_row && col[0];
  assign lb_addr   = AW'(col >> 1);
  assign lb_rd     = lb[lb_addr];

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (fire)
      state_nx = state == IDLE ? EVEN : !end_row ? state : state == EVEN ? ODD : end_frame ? IDLE : EVEN;
  end

  // The first beat of a frame uses the live mode pin; later beats use the latched copy.
  always_comb begin
    odd_row = state == ODD;
    avg     = state == IDLE ? mode : mode_r;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DATA_W-1:0] a, b, q_t;
    logic signed [LW-1:0]     p, l, m;
    logic signed [DATA_W+1:0] s, q;
    assign a = hold[c*DATA_W +: DATA_W];
    assign b = in_data[c*DATA_W +: DATA_W];
    assign p = avg ? {a[DATA_W-1], a} + {b[DATA_W-1], b} : (a > b ? {a[DATA_W-1], a} : {b[DATA_W-1], b});
    assign l = lb_rd[c*LW +: LW];
    assign s = {l[LW-1], l} + {p[LW-1], p};
    assign q = s >>> 2;
    assign m = l > p ? l : p;
    assign q_t = avg ? q[DATA_W-1:0] : m[DATA_W-1:0];
    assign pair[c*LW +: LW] = p;
    assign result[c*DATA_W +: DATA_W] = q_t;
  end

  always_ff @(posedge clk)
    if (fire && !odd_row && col[0]) lb[lb_addr] <= pair;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col       <= '0;
      row       <= '0;
      mode_r    <= 1'b0;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      if (fire) begin
        col <= end_row ? '0 : col + CW'(1);
        if (end_row) row <= end_frame ? '0 : row + RW'(1);
        if (!col[0]) hold <= in_data;
        if (state == IDLE) mode_r <= mode;
      end
      if (load) begin
        out_data <= result;
        out_last <= end_frame;
      end
      out_valid <= load || (out_valid && !out_ready);
    end
endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream: directed frames with a queue scoreboard checked by an independent output monitor
module tb_max_pool_stream;
  localparam int DW = 16, CH = 2, W = 4, H = 4;

  logic clk = 0, rst = 1, in_valid = 0, mode = 0, out_ready = 1;
  logic in_ready, out_valid, out_last;
  logic [CH*DW-1:0] in_data = '0, out_data;

  int checks = 0, errors = 0, acc_cnt = 0;
  bit chk_lat = 0;
  logic [CH*DW:0] sb [$];
  logic [CH*DW:0] exp_q;

  logic [DW-1:0] mx0 [4] = '{16'd5, 16'd7, 16'd13, 16'd15};
  logic [DW-1:0] mx1 [4] = '{16'h0000, 16'hFFFE, 16'hFFF8, 16'hFFF6};
  logic [DW-1:0] av0 [4] = '{16'd2, 16'd4, 16'd10, 16'd12};
  logic [DW-1:0] av1 [4] = '{16'hFFFD, 16'hFFFB, 16'hFFF5, 16'hFFF3};

  max_pool_stream #(.DATA_W(DW), .CH(CH), .FM_W(W), .FM_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", {out_last, out_data});
      end else begin
        exp_q = sb.pop_front();
        chk("output", {out_last, out_data}, exp_q);
      end
    end

  task automatic send(input logic [CH*DW-1:0] d, input logic m);
    in_valid = 1;
    in_data  = d;
    mode     = m;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_cnt++;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got in_ready=0 for 100 cycles expected 1");
    acc_cnt++;
  endtask

  // kind: 0 = ramp (ch0 = i, ch1 = -i), 1 = all 0x7FFF, 2 = all 0x8000
  task automatic frame(input int kind, input logic m0, input bit tog, input bit exp_avg, input int nb);
    int r, c, k;
    logic [DW-1:0] v0, v1;
    logic [CH*DW:0] e;
    for (int i = 0; i < nb; i++) begin
      r  = i / W;
      c  = i % W;
      v0 = kind == 0 ? DW'(i) : kind == 1 ? 16'h7FFF : 16'h8000;
      v1 = kind == 0 ? DW'(-i) : v0;
      if (r % 2 == 1 && c % 2 == 1 && nb == W * H) begin
        k = (r / 2) * 2 + c / 2;
        e = kind != 0 ? {k == 3, v1, v0} : exp_avg ? {k == 3, av1[k], av0[k]} : {k == 3, mx1[k], mx0[k]};
        sb.push_back(e);
      end
      send({v1, v0}, (tog && i >= 3) ? ~m0 : m0);
      if (chk_lat) chk("latency", 64'(out_valid), 64'(r % 2 == 1 && c % 2 == 1));
    end
    in_valid = 0;
  endtask

  task automatic stall();
    wait (acc_cnt == 5);
    out_ready = 0;
    for (int t = 0; t < 20 && !out_valid; t++) begin
      @(posedge clk);
      #2;
    end
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    repeat (5) begin
      chk("stall_data", 64'({out_last, out_data}), 64'({1'b0, 16'h0000, 16'd5}));
      @(posedge clk);
      #2;
    end
    out_ready = 1;
  endtask

  initial begin
    #1 rst = 0;
    #11;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk_lat = 1;
    frame(0, 1'b0, 0, 0, 16);
    chk_lat = 0;
    frame(0, 1'b1, 0, 1, 16);
    frame(1, 1'b1, 0, 1, 16);
    frame(2, 1'b1, 0, 1, 16);
    frame(1, 1'b0, 0, 0, 16);
    frame(2, 1'b0, 0, 0, 16);
    acc_cnt = 0;
    fork
      frame(0, 1'b0, 0, 0, 16);
      stall();
    join
    frame(0, 1'b0, 0, 0, 6);
    rst = 0;
    #3;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    frame(0, 1'b0, 0, 0, 16);
    frame(0, 1'b1, 1, 1, 16);
    frame(0, 1'b0, 0, 0, 16);
    for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/max_pool_stream.md
# max_pool_stream

Streaming, parametrised 2x2/stride-2 pooling engine for the LeNet feature-map path. It accepts one pixel per beat (all channels in parallel) in raster order over a valid/ready handshake and buffers one half-row internally. It emits one pooled pixel per 2x2 window, in either max or floor-average mode. It sits between a convolution layer's output stream and the next layer's input, replacing fixed-size, unbuffered pooling.

## Interface
- DATA_W, 16, bits per channel sample, signed two's complement
- CH, 6, channels carried in parallel per beat
- FM_W, 28, input feature-map width in pixels; must be even and at least 2
- FM_H, 28, input feature-map height in pixels; must be even and at least 2
- clk  in  1  single clock; all logic is rising-edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat
- in_data  in  CH*DATA_W  one pixel; channel c occupies bits [c*DATA_W +: DATA_W]
- mode  in  1  0 = max, 1 = average; sampled only on the first beat of a frame
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts the pooled pixel
- out_data  out  CH*DATA_W  pooled pixel, same channel packing as in_data
- out_last  out  1  high with the final pooled pixel of a frame

## Operation
- A beat transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
- Counters col (0..FM_W-1) and row (0..FM_H-1) advance only on accepted input beats.
  - col wraps to 0 at FM_W-1 and increments row.
  - row wraps to 0 at FM_H-1 together with col, which ends the frame.
- Frame FSM:
  - IDLE → EVEN on the first accepted beat. mode is latched into mode_r on this beat.
  - EVEN → ODD at the end of an even row.
  - ODD → EVEN at the end of an odd row that is not the last row.
  - ODD → IDLE at the end of the last row.
  - mode changes after the first beat are ignored until the next frame.
- Horizontal stage:
  - An even-col beat is stored in the hold register.
  - On an odd-col beat, pair = max(hold, in) in max mode, or hold + in (DATA_W+1 bits, sign-extended) in average mode. This is computed per channel.
- Line buffer: FM_W/2 entries, each CH*(DATA_W+1) bits.
  - On an even row, pair is written to entry col/2.
  - On an odd row, entry col/2 is read and combined with pair.
- Vertical stage (odd row, odd col):
  - Max mode: result = max(lb, pair).
  - Average mode: result = (lb + pair) >>> 2, computed in DATA_W+2 bits with an arithmetic (floor) shift, then truncated to DATA_W bits. The value always fits.
- All comparisons are signed.
- The result is registered into out_data. out_valid is set. out_last is set when row = FM_H-1 and col = FM_W-1.
- in_ready = rst && (!out_valid || out_ready). The single output register is therefore never overrun.
- While out_valid && !out_ready, out_data and out_last hold stable.

## Timing
- Reset values:
  - in_ready = 0 while rst = 0.
  - out_valid = 0, out_data = 0, out_last = 0.
  - col = row = 0, FSM = IDLE, mode_r = 0, hold register = 0.
  - Line buffer contents are don't-care.
- Latency: out_valid rises the cycle after the odd-row, odd-col beat is accepted.
- Throughput: one input beat per cycle with out_ready held at 1.
- out_valid clears the cycle after a transfer, unless a new result is loaded in that same cycle. Load and drain in the same cycle is allowed and keeps out_valid = 1.
- Reset asserted mid-frame aborts the frame immediately.
  - No output is produced for the partial window.
  - The next accepted beat is treated as row 0, col 0.
- The input side may idle (in_valid = 0) at any point. State is held with no timeout.
- out_last is high for exactly one output transfer per frame.

## Test plan
Bench parameters for all scenarios: CH=2, DATA_W=16, FM_W=4, FM_H=4. Channel 0 sample = row*4+col, channel 1 = -(row*4+col) unless stated.

1. Max mode, out_ready=1, back-to-back beats:
   - ch0 outputs 5, 7, 13, 15; ch1 outputs 0, -2, -8, -10.
   - out_last is high only on the 4th output.
   - Each output arrives one cycle after beats 6, 8, 14, 16.
2. Average mode, same stimulus:
   - ch0 outputs 2, 4, 10, 12.
   - ch1 outputs -3, -5, -11, -13 (floor of negative quarters).
3. Overflow boundary: all samples 0x7FFF in average mode, then all 0x8000:
   - Outputs 0x7FFF, then 0x8000.
   - No wrap in either mode.
4. Backpressure: hold out_ready=0 from the 1st output for 5 cycles while in_valid=1:
   - in_ready falls the same cycle out_valid rises.
   - out_data stays 5 / 0.
   - No beat is lost; the remaining outputs match scenario 1.
5. Reset mid-frame: drive rst low after 6 accepted beats, release, then send a full frame:
   - No output from the aborted frame.
   - The new frame yields scenario-1 results.
6. Mode latch: start a frame with mode=1 and toggle mode to 0 after beat 3:
   - The whole frame produces average results (scenario 2).
   - The next frame, started with mode=0, produces max results.
